// File: rtl/note_sequencer_pkg.sv
// Shared constants and types for the song-playback sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package note_sequencer_pkg;

    localparam int DEF_SONG_AW = 5;
    localparam int DEF_K_W     = 22;
    localparam int DEF_DUR_W   = 6;
    localparam int SEL_W       = 2;
    localparam int NOTE_W      = 6;
    localparam int DATA_W      = 16;

    // song_data layout: [15] rest, [14:9] note, [8:3] dur, [2:0] unused
    localparam int REST_BIT = 15;
    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;
    localparam int END_DUR  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_LOAD   = 3'd3,
        ST_PLAY   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Phase increments of the top octave (notes 52..63, E6..D#7) scaled by 2^8,
    // i.e. round(f * 2^22 / 48000 * 256). Lower octaves are derived by shifting,
    // keeping the extra fraction bits so each entry still rounds to nearest.
    function automatic logic [25:0] top_oct_frac(input int idx);
        case (idx)
            0:       return 26'd29494575;
            1:       return 26'd31248413;
            2:       return 26'd33106541;
            3:       return 26'd35075158;
            4:       return 26'd37160835;
            5:       return 26'd39370534;
            6:       return 26'd41711627;
            7:       return 26'd44191930;
            8:       return 26'd46819719;
            9:       return 26'd49603764;
            10:      return 26'd52553357;
            default: return 26'd55678342;
        endcase
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control/ROM/DDS signal bundle around the note sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; beat/restart are fire-and-forget pulses.
// master: the sequencer (drives song_addr, k, note_valid, note_done, song_done)
// slave:  the surroundings (user controls, beat generator, song ROM, dds)
interface note_sequencer_if #(
    parameter int SONG_AW = note_sequencer_pkg::DEF_SONG_AW,
    parameter int K_W     = note_sequencer_pkg::DEF_K_W
);
    logic                                   play;
    logic                                   restart;
    logic [note_sequencer_pkg::SEL_W-1:0]   song_sel;
    logic                                   beat;
    logic [note_sequencer_pkg::SEL_W+SONG_AW-1:0] song_addr;
    logic [note_sequencer_pkg::DATA_W-1:0]  song_data;
    logic [K_W-1:0]                         k;
    logic                                   note_valid;
    logic                                   note_done;
    logic                                   song_done;

    modport master (
        input  play, restart, song_sel, beat, song_data,
        output song_addr, k, note_valid, note_done, song_done
    );

    modport slave (
        output play, restart, song_sel, beat, song_data,
        input  song_addr, k, note_valid, note_done, song_done
    );
endinterface

// File: rtl/note_sequencer_freq_rom.sv
// Note index -> 22-bit DDS phase increment (48 kHz, 2^22 accumulator); note 0 = silence.
// Latency: 1 cycle (registered output).
// Backpressure: none; looks up every cycle.
// Ports: clk, reset (async active-low), note (6b in), k (K_W out).
module freq_rom
    import note_sequencer_pkg::*;
#(
    parameter int K_W = DEF_K_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note,
    output logic [K_W-1:0]    k
);

    logic [K_W-1:0] tbl [64];

    assign tbl[0] = '0;

    // Note n sits D octaves below the top-octave entry IDX; shift right by
    // 8+D with a half-LSB added for round-to-nearest.
    for (genvar i = 1; i < 64; i++) begin : g_tbl
        localparam int D   = (63 - i) / 12;
        localparam int IDX = i + 12 * D - 52;
        localparam logic [26:0] SUM = 27'(top_oct_frac(IDX)) + (27'd1 << (7 + D));
        assign tbl[i] = K_W'(SUM >> (8 + D));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) k <= '0;
        else        k <= tbl[note];
    end

endmodule

// File: rtl/note_sequencer.sv
// Steps through a song ROM and holds each note's phase increment for its beat count.
// Latency: k valid 3 edges after entering FETCH (ROM read, freq lookup, load).
// Backpressure: none; beats outside PLAY or while paused are dropped.
// Ports: clk, reset (async active-low), bus (note_sequencer_if.master).
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int SONG_AW = DEF_SONG_AW,
    parameter int K_W     = DEF_K_W,
    parameter int DUR_W   = DEF_DUR_W
) (
    input  logic             clk,
    input  logic             reset,
    note_sequencer_if.master bus
);

    state_t                     state, state_nxt;
    logic [SEL_W-1:0]           sel_q, sel_nxt;
    logic [SONG_AW-1:0]         offset, offset_nxt, offset_inc;
    logic [DUR_W-1:0]           cnt, cnt_nxt, dur_q, dur_nxt, data_dur;
    logic                       rest_q, rest_nxt;
    logic [SEL_W+SONG_AW-1:0]   addr_q, addr_nxt;
    logic [K_W-1:0]             k_q, k_nxt, rom_k;
    logic                       valid_q, valid_nxt;
    logic                       ndone_q, ndone_nxt;
    logic                       sdone_q, sdone_nxt;
    logic [NOTE_W-1:0]          rom_note;
    logic                       qual_beat;
    logic                       data_unused;

    assign data_dur    = DUR_W'(bus.song_data[DUR_MSB:DUR_LSB]);
    assign rom_note    = bus.song_data[NOTE_MSB:NOTE_LSB];
    assign data_unused = ^bus.song_data[DUR_LSB-1:0];
    assign qual_beat   = bus.beat & bus.play;
    assign offset_inc  = offset + SONG_AW'(1);

    // The ROM is fed straight from song_data; its register captures the note
    // on the DECODE->LOAD edge, so the value is ready while in LOAD.
    freq_rom #(.K_W(K_W)) u_freq_rom (
        .clk   (clk),
        .reset (reset),
        .note  (rom_note),
        .k     (rom_k)
    );

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel_q;
        offset_nxt = offset;
        cnt_nxt    = cnt;
        dur_nxt    = dur_q;
        rest_nxt   = rest_q;
        addr_nxt   = addr_q;
        k_nxt      = k_q;
        ndone_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.play) begin
                    state_nxt  = ST_FETCH;
                    sel_nxt    = bus.song_sel;
                    offset_nxt = '0;
                    addr_nxt   = {bus.song_sel, {SONG_AW{1'b0}}};
                end
            end
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (data_dur == DUR_W'(END_DUR)) begin
                    state_nxt = ST_DONE;
                    k_nxt     = '0;
                end else begin
                    rest_nxt  = bus.song_data[REST_BIT];
                    dur_nxt   = data_dur;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                k_nxt     = rest_q ? '0 : rom_k;
                cnt_nxt   = dur_q;
                state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (qual_beat && cnt != '0) begin
                    cnt_nxt = cnt - DUR_W'(1);
                    if (cnt == DUR_W'(1)) begin
                        ndone_nxt = 1'b1;
                        // Last entry of the song region: stop instead of wrapping.
                        if (offset == {SONG_AW{1'b1}}) begin
                            state_nxt = ST_DONE;
                            k_nxt     = '0;
                        end else begin
                            offset_nxt = offset_inc;
                            addr_nxt   = {sel_q, offset_inc};
                            state_nxt  = ST_FETCH;
                        end
                    end
                end
            end
            ST_DONE:  k_nxt = '0;
            default:  state_nxt = ST_IDLE;
        endcase

        // restart overrides whatever the state logic decided, including a beat.
        if (bus.restart) begin
            state_nxt  = ST_FETCH;
            sel_nxt    = bus.song_sel;
            offset_nxt = '0;
            addr_nxt   = {bus.song_sel, {SONG_AW{1'b0}}};
            k_nxt      = '0;
            cnt_nxt    = '0;
            ndone_nxt  = 1'b0;
        end

        // Mute the final beat of multi-beat notes so repeats stay separated.
        valid_nxt = (state_nxt == ST_PLAY) && bus.play && !rest_nxt &&
                    ((cnt_nxt > DUR_W'(1)) || (dur_nxt == DUR_W'(1)));
        sdone_nxt = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            sel_q   <= '0;
            offset  <= '0;
            cnt     <= '0;
            dur_q   <= '0;
            rest_q  <= 1'b0;
            addr_q  <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            ndone_q <= 1'b0;
            sdone_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel_q   <= sel_nxt;
            offset  <= offset_nxt;
            cnt     <= cnt_nxt;
            dur_q   <= dur_nxt;
            rest_q  <= rest_nxt;
            addr_q  <= addr_nxt;
            k_q     <= k_nxt;
            valid_q <= valid_nxt;
            ndone_q <= ndone_nxt;
            sdone_q <= sdone_nxt;
        end
    end

    assign bus.song_addr  = addr_q;
    assign bus.k          = k_q;
    assign bus.note_valid = valid_q;
    assign bus.note_done  = ndone_q;
    assign bus.song_done  = sdone_q;

endmodule
